// File: rtl/md5_pkg.sv
// ============================================================================
// Module   : md5_pkg
// Purpose  : Shared types and constants for the MD5 brute-force job scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package md5_pkg;

    localparam int          c_CAND_W        = 32;
    localparam logic [31:0] c_DEFAULT_CHUNK = 32'h0000_1000;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        RUN    = 2'd1,
        RETIRE = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ABORT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/md5_sched_rr.sv
// ============================================================================
// Module   : md5_sched_rr
// Purpose  : Round-robin picker: first free slot at or after the pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md5_sched_rr #(
    parameter int NUM_WORKERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_WORKERS-1:0] free,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_WORKERS-1:0] grant,
    output logic                   valid
);

    int               w_idx;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        w_idx = 0;
        w_sel = '0;
        for (int off = 0; off < NUM_WORKERS; off++) begin
            w_idx = int'(ptr) + off;
            if (w_idx >= NUM_WORKERS) begin
                w_idx = w_idx - NUM_WORKERS;
            end
            w_sel = IDX_W'(w_idx);
            if (!valid && free[w_sel]) begin
                grant[w_sel] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/md5_bf_sched.sv
// ============================================================================
// Module   : md5_bf_sched
// Purpose  : Splits a candidate range into chunks, dispatches them round-robin
//            to md5_bf workers and aborts all of them on the first match.
// Options  : MD5_SCHED_STATS_EN adds cycles/chunks statistics outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md5_bf_sched
    import md5_pkg::*;
#(
    parameter int          NUM_WORKERS = 4,
    parameter logic [31:0] CHUNK       = c_DEFAULT_CHUNK
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [c_CAND_W-1:0]             job_low,
    input  logic [c_CAND_W-1:0]             job_high,
    output logic                            busy,
    output logic                            done,
    output logic                            found,
    output logic [c_CAND_W-1:0]             pass,
    output logic [NUM_WORKERS-1:0]          w_rst_n,
    output logic [NUM_WORKERS-1:0]          w_start,
    output logic [c_CAND_W*NUM_WORKERS-1:0] w_low,
    output logic [c_CAND_W*NUM_WORKERS-1:0] w_high,
    input  logic [NUM_WORKERS-1:0]          w_done,
    input  logic [NUM_WORKERS-1:0]          w_found,
    input  logic [c_CAND_W*NUM_WORKERS-1:0] w_pass
`ifdef MD5_SCHED_STATS_EN
    ,
    output logic [31:0]                     cycles,
    output logic [15:0]                     chunks
`endif
);

    localparam int c_IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    state_t                          r_state;
    slot_t                           r_slot [NUM_WORKERS];
    logic [c_IDX_W-1:0]              r_ptr;
    logic [c_CAND_W-1:0]             r_next_low;
    logic [c_CAND_W-1:0]             r_job_high;
    logic                            r_exhausted;
    logic                            r_init;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_found;
    logic [c_CAND_W-1:0]             r_pass;
    logic [NUM_WORKERS-1:0]          r_w_rst_n;
    logic [NUM_WORKERS-1:0]          r_w_start;
    logic [c_CAND_W*NUM_WORKERS-1:0] r_w_low;
    logic [c_CAND_W*NUM_WORKERS-1:0] r_w_high;

    logic                    w_accept;
    logic [c_CAND_W-1:0]     w_cur_low;
    logic [c_CAND_W-1:0]     w_cur_high;
    logic                    w_cur_exh;
    logic [c_CAND_W-1:0]     w_span;
    logic [c_CAND_W-1:0]     w_chunk_high;
    logic [NUM_WORKERS-1:0]  w_free;
    logic [NUM_WORKERS-1:0]  w_grant;
    logic                    w_rr_valid;
    logic [c_IDX_W-1:0]      w_grant_idx;
    logic [c_IDX_W-1:0]      w_ptr_next;
    logic                    w_dispatch;
    logic [c_CAND_W-1:0]     w_found_pass;

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_free
        assign w_free[g] = (r_slot[g] == FREE);
    end

    md5_sched_rr #(
        .NUM_WORKERS (NUM_WORKERS),
        .IDX_W       (c_IDX_W)
    ) u_rr (
        .free  (w_free),
        .ptr   (r_ptr),
        .grant (w_grant),
        .valid (w_rr_valid)
    );

    // The accepting cycle dispatches straight from the job inputs so the first
    // chunk goes out in the same cycle busy rises.
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !r_init;
    assign w_cur_low  = w_accept ? job_low  : r_next_low;
    assign w_cur_high = w_accept ? job_high : r_job_high;
    assign w_cur_exh  = w_accept ? (job_low > job_high) : r_exhausted;
    assign w_dispatch = (w_accept || ((r_state == S_RUN) && (w_found == '0)))
                        && !w_cur_exh && w_rr_valid;

    // Remaining span compared against CHUNK-1 so the top of the range never wraps.
    assign w_span       = w_cur_high - w_cur_low;
    assign w_chunk_high = (w_span < (CHUNK - 32'd1)) ? w_cur_high
                                                     : (w_cur_low + (CHUNK - 32'd1));

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == c_IDX_W'(NUM_WORKERS - 1)) ? '0
                                                                  : (w_grant_idx + c_IDX_W'(1));

    // Descending scan so the lowest-indexed reporting worker wins.
    always_comb begin
        w_found_pass = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (w_found[i]) begin
                w_found_pass = w_pass[i*c_CAND_W +: c_CAND_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_next_low  <= '0;
            r_job_high  <= '0;
            r_exhausted <= 1'b0;
            r_init      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_pass      <= '0;
            r_w_rst_n   <= '0;
            r_w_start   <= '0;
            r_w_low     <= '0;
            r_w_high    <= '0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_slot[i] <= FREE;
            end
        end else begin
            r_init    <= 1'b0;
            r_w_start <= '0;

            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_w_rst_n[i] <= !r_init;
                case (r_slot[i])
                    RUN: begin
                        if ((r_state == S_RUN) && w_done[i]) begin
                            r_slot[i]    <= RETIRE;
                            r_w_rst_n[i] <= 1'b0;
                        end
                    end
                    RETIRE:  r_slot[i] <= FREE;
                    default: r_slot[i] <= r_slot[i];
                endcase
            end

            if (w_accept) begin
                r_next_low  <= job_low;
                r_job_high  <= job_high;
                r_exhausted <= (job_low > job_high);
            end

            if (w_dispatch) begin
                for (int i = 0; i < NUM_WORKERS; i++) begin
                    if (w_grant[i]) begin
                        r_slot[i]                          <= RUN;
                        r_w_start[i]                       <= 1'b1;
                        r_w_low[i*c_CAND_W +: c_CAND_W]    <= w_cur_low;
                        r_w_high[i*c_CAND_W +: c_CAND_W]   <= w_chunk_high;
                    end
                end
                r_ptr <= w_ptr_next;
                if (w_chunk_high == w_cur_high) begin
                    r_exhausted <= 1'b1;
                end else begin
                    r_next_low <= w_chunk_high + 32'd1;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_found <= 1'b0;
                        r_pass  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_found != '0) begin
                        r_state   <= S_ABORT;
                        r_pass    <= w_found_pass;
                        r_w_rst_n <= '0;
                    end else if (r_exhausted && (w_free == '1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_ABORT: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_found <= 1'b1;
                    for (int i = 0; i < NUM_WORKERS; i++) begin
                        r_slot[i] <= FREE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign found   = r_found;
    assign pass    = r_pass;
    assign w_rst_n = r_w_rst_n;
    assign w_start = r_w_start;
    assign w_low   = r_w_low;
    assign w_high  = r_w_high;

`ifdef MD5_SCHED_STATS_EN
    logic [31:0] r_cycles;
    logic [15:0] r_chunks;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cycles <= '0;
            r_chunks <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
            r_chunks <= w_dispatch ? 16'd1 : 16'd0;
        end else begin
            if (r_busy) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (w_dispatch && (r_chunks != 16'hFFFF)) begin
                r_chunks <= r_chunks + 16'd1;
            end
        end
    end

    assign cycles = r_cycles;
    assign chunks = r_chunks;
`endif

endmodule

`default_nettype wire

// File: doc/md5_bf_sched.md
# md5_bf_sched

Job scheduler for the MD5 password-cracking array. Splits a 32-bit candidate range into fixed-size chunks, dispatches them round-robin to NUM_WORKERS md5_bf workers, collects their done/found results, and aborts all workers as soon as one reports a match. Sits between the UART/command front end (start, range, hash) and the replicated md5_bf instances.

## Interface
- NUM_WORKERS, 4: number of md5_bf instances driven (1..16).
- CHUNK, 32'h0000_1000: candidate values per dispatched chunk (>=1).
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low; clock clk.
- start  in  1  job start pulse; sampled only in S_IDLE / S_DONE.
- job_low, job_high  in  32 each  inclusive candidate range (8 BCD nibbles); sampled at accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  level, high in S_DONE.
- found  out  1  valid with done; 1 = match found.
- pass  out  32  matching candidate; 0 when found=0.
- w_rst_n  out  NUM_WORKERS  per-worker synchronous active-low reset to md5_bf.
- w_start  out  NUM_WORKERS  per-worker one-cycle start pulse.
- w_low, w_high  out  32*NUM_WORKERS  per-worker chunk bounds, registered, stable while the worker is running.
- w_done  in  NUM_WORKERS  worker done level (sticky until worker reset).
- w_found  in  NUM_WORKERS  one-cycle pulse, asserted the cycle before w_done rises.
- w_pass  in  32*NUM_WORKERS  valid in the w_found cycle.

## Operation
- Top FSM: S_IDLE, S_RUN, S_ABORT, S_DONE.
- S_IDLE/S_DONE + start: latch job bounds, next_low <= job_low, exhausted <= (job_low > job_high), -> S_RUN.
- Per-worker slot: FREE -> RUN (w_start pulsed) -> RETIRE (w_done seen; w_rst_n low one cycle) -> FREE.
- S_RUN dispatch: at most one chunk per cycle, to the first FREE slot at or after round-robin pointer; pointer advances past the granted slot.
- Chunk bounds: w_low = next_low; w_high = job_high if (job_high - next_low) < CHUNK-1, else next_low + CHUNK - 1. Subtraction-based, no 32-bit overflow. If w_high == job_high, exhausted <= 1; else next_low <= w_high + 1.
- w_found captured every cycle it is high, independent of w_done. Simultaneous pulses: lowest worker index wins; pass <= its w_pass; -> S_ABORT.
- S_RUN, exhausted and all slots FREE with no found -> S_DONE, found=0, pass=0.
- S_ABORT: all w_rst_n low for exactly one cycle, all slots -> FREE, -> S_DONE, found=1.
- S_DONE: done=1, found/pass held until next accepted start; start returns to S_RUN with found/pass cleared.
- start ignored in S_RUN/S_ABORT.

## Timing
- Reset: state S_IDLE, busy=0, done=0, found=0, pass=0, w_start=0, w_low=w_high=0, all slots FREE, w_rst_n all low during reset and for one cycle after.
- start accepted at cycle T: busy=1 at T+1, first w_start at T+1 with bounds valid the same cycle.
- w_done rising at T: w_rst_n low at T+1, slot re-dispatchable at T+2.
- w_found at T: S_ABORT at T+1, done=1 at T+2.
- reset_n low mid-job: immediate return to reset values, in-flight results discarded.

## Configuration
- MD5_SCHED_STATS_EN defined: adds outputs cycles[31:0] (counts clocks while busy, frozen in S_DONE, cleared on accepted start) and chunks[15:0] (chunks dispatched, same clear rule, saturating).
- Undefined: ports absent, no counter logic; all other behaviour identical.

## Structure
- Package md5_pkg: slot state enum (FREE/RUN/RETIRE), top FSM enum, default CHUNK, candidate width constant 32.
- Sub-module md5_sched_rr: round-robin first-free picker (free mask + pointer -> grant one-hot, valid). Chunk arithmetic and FSM stay in the top.

## Test plan
- job 0..00000099 hex-BCD, CHUNK=16, NUM_WORKERS=4, no match -> 10 chunks dispatched in order 0-F,10-1F,..., 90-99; done with found=0, pass=0.
- job 00000000..00009999, match at 00001234 -> w_found from the owning worker; ABORT pulses all w_rst_n one cycle; done=1, found=1, pass=32'h00001234.
- Two models pulse w_found same cycle on workers 1 and 3 -> pass from worker 1.
- job_low=5, job_high=3 -> no w_start, done two cycles after start, found=0.
- job FFFFFFF0..FFFFFFFF, CHUNK=16 -> single chunk w_high=FFFFFFFF, no wrap to 0, done after it retires.
- reset_n low during S_RUN -> all outputs return to reset values next cycle; new start runs cleanly.
